// File: rtl/serial_mul_unit.sv
// Iterative shift-and-add multiplier: one partial product per clock, WIDTH
// iterations per request, signed operands handled as magnitudes plus a sign.
module serial_mul_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 signed_mode,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 mul_done
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  // Operands widened by one bit so the most-negative value has an exact magnitude.
  logic [WIDTH:0]       a_ext, b_ext, a_mag, b_mag;
  logic [2*WIDTH-1:0]   addend, sum;

  // Sign-extend (signed mode) or zero-extend, then take magnitudes.
  always_comb begin
    a_ext  = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    b_ext  = {signed_mode & multiplier[WIDTH-1], multiplier};
    a_mag  = a_ext[WIDTH] ? -a_ext : a_ext;
    b_mag  = b_ext[WIDTH] ? -b_ext : b_ext;
    addend = mplier_q[0] ? mcand_q : '0;
    sum    = acc_q + addend;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: accept in IDLE, leave RUN after the last iteration.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CntLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy     = (state_q == StRun);
    mul_done = done_q;
    product  = product_q;
  end

  // Datapath next state: capture on accept, accumulate/shift while running.
  always_comb begin
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = {{(WIDTH-1){1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          cnt_d    = '0;
          acc_d    = '0;
        end
      end
      StRun: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          product_d = neg_q ? -sum : sum;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_mul_unit.sv
// Scoreboard bench for serial_mul_unit (WIDTH=8): expected products queued at
// request time, compared whenever mul_done pulses.
module tb_serial_mul_unit;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           signed_mode;
  logic [2*W-1:0] product;
  logic           busy;
  logic           mul_done;

  int n_total = 0;
  int n_bad   = 0;
  int n_acc   = 0;
  int n_done  = 0;
  logic [2*W-1:0] sb_q[$];

  serial_mul_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .signed_mode  (signed_mode),
    .product      (product),
    .busy         (busy),
    .mul_done     (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    int pa, pb, p;
    pa = s ? int'($signed(a)) : int'(a);
    pb = s ? int'($signed(b)) : int'(b);
    p  = pa * pb;
    return p[2*W-1:0];
  endfunction

  // Completion monitor: every pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst && mul_done) begin
      n_done++;
      check_val("busy_in_done", {31'b0, busy}, 32'd0);
      if (sb_q.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        check_val("product", {16'b0, product}, {16'b0, sb_q.pop_front()});
      end
    end
  end

  // Drive a request at a negedge; accepted on the following posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    signed_mode  = s;
    sb_q.push_back(ref_mul(a, b, s));
    n_acc++;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom_range(0, 255);
    multiplier   = $urandom_range(0, 255);
    signed_mode  = 1'($urandom_range(0, 1));
  endtask

  // Wait for mul_done from the current negedge, counting busy cycles.
  task automatic wait_done(input string tag, input int exp_busy);
    int  nb;
    bit  seen;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mul_done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
    if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    else       check_val({tag, "_busy_cycles"}, nb, exp_busy);
  endtask

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    issue(a, b, s);
    wait_done("op", W);
  endtask

  initial begin
    int nb;
    bit seen;
    rst          = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    signed_mode  = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_product", {16'b0, product}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, mul_done}, 32'd0);
    rst = 1'b1;

    // Directed unsigned and signed cases.
    do_mul(8'd13, 8'd11, 1'b0);
    check_val("d_13x11", {16'b0, product}, 32'h008F);
    do_mul(8'd255, 8'd255, 1'b0);
    check_val("d_max", {16'b0, product}, 32'hFE01);
    do_mul(8'd0, 8'd200, 1'b0);
    check_val("d_zero", {16'b0, product}, 32'h0000);
    do_mul(8'hFD, 8'h05, 1'b1);
    check_val("d_neg3x5", {16'b0, product}, 32'hFFF1);
    do_mul(8'h80, 8'h80, 1'b1);
    check_val("d_minxmin", {16'b0, product}, 32'h4000);
    do_mul(8'h80, 8'h7F, 1'b1);
    check_val("d_minxmax", {16'b0, product}, 32'hC080);

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(8'd5, 8'd6, 1'b0);
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd2; multiplier = 8'd2; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done("prot_first", W - 2);
    check_val("prot_hold", {16'b0, product}, 32'd30);
    start = 1'b1; multiplicand = 8'd3; multiplier = 8'd4; signed_mode = 1'b0;
    sb_q.push_back(16'd12);
    n_acc++;
    @(negedge clk);
    start = 1'b0;
    nb   = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mul_done) begin
        seen = 1'b1;
        break;
      end
      nb++;
      @(negedge clk);
    end
    check_val("b2b_latency", seen ? nb : 0, 32'd9);
    check_val("b2b_product", {16'b0, product}, 32'd12);

    // Reset mid-operation aborts with no completion.
    issue(8'd9, 8'd9, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("abort_product", {16'b0, product}, 32'd0);
    check_val("abort_busy", {31'b0, busy}, 32'd0);
    check_val("abort_done", {31'b0, mul_done}, 32'd0);
    void'(sb_q.pop_back());
    n_acc--;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mul_done) seen = 1'b1;
      if (i == 2) rst = 1'b1;
    end
    check_val("abort_no_done", {31'b0, seen}, 32'd0);
    do_mul(8'd7, 8'd6, 1'b0);
    check_val("post_rst", {16'b0, product}, 32'd42);

    // Random operands, modes and idle gaps.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check_val("done_count", n_done, n_acc);
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
